store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write FIFO between the single-cycle core's store path and data memory.
//  Accepts sb/sh/sw from the core, converts them to word address + byte enables + lane-aligned data, queues them, and drains them in order over a req/ack memory port.
//  Loads see queued stores through per-byte forwarding, so the core never reads stale data.
// PARAMETERS
//  DEPTH  4   entries; power of 2, >=2
//  AW     32  byte-address width
// PORTS
//  clk           in   1      clock, all state on rising edge
//  reset         in   1      synchronous, active-high
//  st_valid      in   1      core presents a store this cycle
//  st_addr       in   AW     byte address (ALUResult)
//  st_wdata      in   32     unshifted rs2 value (WriteData)
//  st_funct3     in   3      000 sb, 001 sh, 010 sw; others illegal
//  st_ready      out  1      store accepted if st_valid is high this cycle
//  st_misalign   out  1      comb; st_valid with illegal funct3 or misaligned address
//  ld_addr       in   AW     load byte address for forwarding lookup
//  ld_fwd_mask   out  4      comb; bit i = byte lane i supplied by buffer
//  ld_fwd_data   out  32     comb; forwarded lanes, 0 elsewhere
//  mem_req       out  1      head entry valid and offered to memory
//  mem_addr      out  AW     {word address, 2'b00} of head
//  mem_be        out  4      head byte enables
//  mem_wdata     out  32     head lane-aligned data
//  mem_ack       in   1      memory accepted head this cycle; ignored when !mem_req
//  empty         out  1      no entries (fence/ecall drain condition)
//  count         out  $clog2(DEPTH+1)  occupancy
// BEHAVIOUR
//  Reset: all entries invalid, wr/rd pointers 0, count=0, empty=1, mem_req=0, st_ready=1.
//   Reset mid-drain abandons the in-flight head; no further mem_req until a new push.
//  Lane formatting: sb be=1<<a[1:0], data=byte replicated x4; sh be=a[1]?1100:0011, data=half replicated x2;
//   sw be=1111. Misaligned (sh a[0]!=0, sw a[1:0]!=0) or illegal funct3 -> st_misalign=1, no push.
//  Push when st_valid & st_ready & !st_misalign; entry visible to forwarding and mem port next cycle.
//  st_ready = !full. When full, a push is refused even if mem_ack pops that cycle (no bypass).
//  Drain: mem_req = !empty; mem_addr/be/wdata are driven directly from head entry, stable until ack.
//   On mem_ack & mem_req, head pops at the clock edge. Single-entry latency push->mem_req: 1 cycle.
//   Simultaneous push+pop: count unchanged, pointers both advance, wrap modulo DEPTH.
//  Forwarding: ld_addr word compared against every valid entry, including head; per lane, the
//   youngest entry whose be covers that lane wins. Entry popping this cycle is still forwarded.
//   Same-cycle push is NOT forwarded (core cannot load and store in one instruction).
//  count is exact arithmetic; never exceeds DEPTH, never underflows (pop only when !empty).
// CONFIGURATION
//  STORE_BUFFER_COALESCE_EN defined: a push whose word address equals the youngest entry, where
//   that entry is not the head (count>=2), merges into it instead of allocating:
//   be|=new_be, new lanes overwrite. Merge is allowed while full; st_ready = !full | merge_hit.
//  Not defined: every accepted store allocates its own entry; st_ready = !full.
// STRUCTURE
//  Package riscv_mem_pkg: typedef sb_entry_t {valid, waddr, be[3:0], data[31:0]}; funct3 localparams
//   F3_SB/F3_SH/F3_SW; helper functions for lane be/data formatting (shared with dmem load path).
//  Sub-module sb_fwd_merge: combinational youngest-wins per-lane priority across DEPTH entries.
// TESTING
//  1 sw 0x64<-25, mem_ack tied 1 -> next cycle mem_req=1, addr 0x64, be 1111, data 0x19; pops that edge, empty=1.
//  2 mem_ack=0, 5 sw pushes DEPTH=4 -> st_ready=0 after 4th, 5th refused, count=4; ack x4 -> in-order drain.
//  3 sb 0x101<-0xAB, then sh 0x102<-0x1234, ld_addr=0x100 -> mask 1110, data 0x1234AB00.
//  4 sh at 0x103, sw at 0x102, funct3=011 -> st_misalign=1, count unchanged.
//  5 full buffer, push + mem_ack same cycle -> push refused, count=3; wrap past index DEPTH-1 correct.
//  6 reset asserted with 3 entries and mem_req high -> next cycle count=0, mem_req=0, empty=1.
//  7 COALESCE_EN: two sb to word 0x40 behind a pending head -> count+1 once, merged be 0011.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared memory-path definitions for the store buffer and the data-memory load path.
// Contents: store funct3 encodings, the store-buffer entry record, and helpers that
// turn a core store (funct3, byte address, rs2 value) into byte enables and
// lane-aligned write data.
package riscv_mem_pkg;

    localparam int SB_AW = 32;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-3:0] waddr;
        logic [3:0]       be;
        logic [31:0]      data;
    } sb_entry_t;

    // Byte enables of a store within its word.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            F3_SB:   be = 4'b0001 << a;
            F3_SH:   be = a[1] ? 4'b1100 : 4'b0011;
            F3_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the stored byte/half across the word so every enabled lane carries it.
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] d;
        case (f3)
            F3_SB:   d = {4{wdata[7:0]}};
            F3_SH:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Illegal funct3 is reported as misaligned so it is never queued.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3)
            F3_SB:   m = 1'b0;
            F3_SH:   m = a[0];
            F3_SW:   m = (a != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    // Overwrite the lanes selected by new_be, keep the rest.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_d,
                                                input logic [31:0] new_d,
                                                input logic [3:0]  new_be);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) begin
            r[8*l +: 8] = new_be[l] ? new_d[8*l +: 8] : old_d[8*l +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Per-lane store-to-load forwarding across all store-buffer entries.
// Entries are visited oldest (head) to youngest, so the youngest matching entry
// covering a lane supplies that lane.
// Ports:
//   entries_i   all buffer entries
//   rd_ptr_i    head index (oldest entry)
//   ld_waddr_i  load word address
//   fwd_mask_o  lanes supplied by the buffer
//   fwd_data_o  forwarded lanes, zero elsewhere
module sb_fwd_merge
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries_i,
    input  logic [PW-1:0]         rd_ptr_i,
    input  logic [SB_AW-3:0]      ld_waddr_i,
    output logic [3:0]            fwd_mask_o,
    output logic [31:0]           fwd_data_o
);

    // Age-ordered scan; later (younger) hits overwrite earlier ones lane by lane.
    always_comb begin
        fwd_mask_o = 4'b0000;
        fwd_data_o = 32'h0000_0000;
        for (int k = 0; k < DEPTH; k++) begin
            if (entries_i[PW'(rd_ptr_i + PW'(k))].valid &&
                (entries_i[PW'(rd_ptr_i + PW'(k))].waddr == ld_waddr_i)) begin
                for (int l = 0; l < 4; l++) begin
                    if (entries_i[PW'(rd_ptr_i + PW'(k))].be[l]) begin
                        fwd_mask_o[l]        = 1'b1;
                        fwd_data_o[8*l +: 8] = entries_i[PW'(rd_ptr_i + PW'(k))].data[8*l +: 8];
                    end else begin
                        fwd_mask_o[l] = fwd_mask_o[l];
                    end
                end
            end else begin
                fwd_mask_o = fwd_mask_o;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core store path and data memory.
// Formats sb/sh/sw into word address + byte enables + lane data, queues them,
// drains in order over a req/ack port and forwards queued bytes to loads.
// Optional build macro: STORE_BUFFER_COALESCE_EN merges a store into the youngest
// non-head entry of the same word instead of allocating a new one.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   st_valid/st_addr/st_wdata/st_funct3  core store request
//   st_ready, st_misalign          acceptance / bad alignment or funct3
//   ld_addr, ld_fwd_mask, ld_fwd_data    load forwarding lookup
//   mem_req/mem_addr/mem_be/mem_wdata/mem_ack  memory drain port (head entry)
//   empty, count                   occupancy
module store_buffer
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_wdata,
    input  logic [2:0]    st_funct3,
    output logic          st_ready,
    output logic          st_misalign,
    input  logic [AW-1:0] ld_addr,
    output logic [3:0]    ld_fwd_mask,
    output logic [31:0]   ld_fwd_data,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    output logic          empty,
    output logic [CW-1:0] count
);

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    logic          push_alloc_s;
    logic          push_merge_s;
    logic          merge_hit_s;
    logic [PW-1:0] young_ptr_s;
    logic [3:0]    new_be_s;
    logic [31:0]   new_data_s;

    assign full_s      = (count_q == CW'(DEPTH));
    assign empty_s     = (count_q == CW'(0));
    assign young_ptr_s = wr_ptr_q - PW'(1);
    assign new_be_s    = lane_be(st_funct3, st_addr[1:0]);
    assign new_data_s  = lane_data(st_funct3, st_wdata);
    assign st_misalign = st_valid && is_misaligned(st_funct3, st_addr[1:0]);

`ifdef STORE_BUFFER_COALESCE_EN
    // Merge only behind the head, so the entry being offered to memory never changes.
    assign merge_hit_s = st_valid && !st_misalign && (count_q >= CW'(2)) &&
                         entries_q[young_ptr_s].valid &&
                         (entries_q[young_ptr_s].waddr == st_addr[AW-1:2]);
    assign st_ready    = !full_s || merge_hit_s;
`else
    assign merge_hit_s = 1'b0;
    assign st_ready    = !full_s;
`endif

    // Full buffer refuses a push even when the head pops this cycle.
    assign push_s       = st_valid && st_ready && !st_misalign;
    assign push_alloc_s = push_s && !merge_hit_s;
    assign push_merge_s = push_s && merge_hit_s;
    assign pop_s        = mem_ack && !empty_s;

    assign mem_req   = !empty_s;
    assign mem_addr  = {entries_q[rd_ptr_q].waddr, 2'b00};
    assign mem_be    = entries_q[rd_ptr_q].be;
    assign mem_wdata = entries_q[rd_ptr_q].data;
    assign empty     = empty_s;
    assign count     = count_q;

    // Next-state for queue contents, pointers and occupancy.
    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + CW'(push_alloc_s) - CW'(pop_s);
        if (pop_s) begin
            entries_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d                  = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_alloc_s) begin
            entries_d[wr_ptr_q].valid = 1'b1;
            entries_d[wr_ptr_q].waddr = st_addr[AW-1:2];
            entries_d[wr_ptr_q].be    = new_be_s;
            entries_d[wr_ptr_q].data  = new_data_s;
            wr_ptr_d                  = wr_ptr_q + PW'(1);
        end else if (push_merge_s) begin
            entries_d[young_ptr_s].be   = entries_q[young_ptr_s].be | new_be_s;
            entries_d[young_ptr_s].data = merge_lanes(entries_q[young_ptr_s].data,
                                                      new_data_s, new_be_s);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // State registers; reset drops every entry, including an in-flight head.
    always_ff @(posedge clk) begin
        if (reset) begin
            entries_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd (
        .entries_i  (entries_q),
        .rd_ptr_i   (rd_ptr_q),
        .ld_waddr_i (ld_addr[AW-1:2]),
        .fwd_mask_o (ld_fwd_mask),
        .fwd_data_o (ld_fwd_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (DEPTH=4): a formatting vector table plus
// hand-written sequences for fill/drain, forwarding, wrap, reset and coalescing.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [2:0]  st_funct3;
    logic        st_ready;
    logic        st_misalign;
    logic [31:0] ld_addr;
    logic [3:0]  ld_fwd_mask;
    logic [31:0] ld_fwd_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        empty;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_funct3(st_funct3),
        .st_ready(st_ready), .st_misalign(st_misalign),
        .ld_addr(ld_addr), .ld_fwd_mask(ld_fwd_mask), .ld_fwd_data(ld_fwd_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mis;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_wdata  = d;
        step();
        st_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_addr = 32'h0; st_wdata = 32'h0;
        st_funct3 = 3'b010; ld_addr = 32'h0; mem_ack = 1'b0;

        vecs[0] = '{3'b010, 32'h0000_0064, 32'h0000_0019, 1'b0, 32'h0000_0064, 4'b1111, 32'h0000_0019};
        vecs[1] = '{3'b000, 32'h0000_0101, 32'h0000_00AB, 1'b0, 32'h0000_0100, 4'b0010, 32'hABAB_ABAB};
        vecs[2] = '{3'b000, 32'h0000_0203, 32'h1234_56CD, 1'b0, 32'h0000_0200, 4'b1000, 32'hCDCD_CDCD};
        vecs[3] = '{3'b000, 32'h0000_0000, 32'h0000_0042, 1'b0, 32'h0000_0000, 4'b0001, 32'h4242_4242};
        vecs[4] = '{3'b001, 32'h0000_0102, 32'h0000_1234, 1'b0, 32'h0000_0100, 4'b1100, 32'h1234_1234};
        vecs[5] = '{3'b001, 32'h0000_0300, 32'hFFFF_5678, 1'b0, 32'h0000_0300, 4'b0011, 32'h5678_5678};
        vecs[6] = '{3'b001, 32'h0000_0103, 32'h0000_1111, 1'b1, 32'h0, 4'b0000, 32'h0};
        vecs[7] = '{3'b010, 32'h0000_0102, 32'h2222_2222, 1'b1, 32'h0, 4'b0000, 32'h0};
        vecs[8] = '{3'b011, 32'h0000_0100, 32'h3333_3333, 1'b1, 32'h0, 4'b0000, 32'h0};

        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd1);

        // Single sw with ack held high: ack ignored while empty, then pops next edge.
        mem_ack = 1'b1;
        push(3'b010, 32'h64, 32'd25);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h64);
        chk("t1_mem_be", 32'(mem_be), 32'hF);
        chk("t1_mem_wdata", mem_wdata, 32'h19);
        step();
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_req_off", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;

        // Lane formatting and misalignment table.
        for (int i = 0; i < 9; i++) begin
            st_valid = 1'b1; st_funct3 = vecs[i].f3; st_addr = vecs[i].addr; st_wdata = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d_misalign", i), 32'(st_misalign), 32'(vecs[i].mis));
            step();
            st_valid = 1'b0;
            if (!vecs[i].mis) begin
                chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'd1);
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].maddr);
                chk($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].be));
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].data);
                mem_ack = 1'b1;
                step();
                mem_ack = 1'b0;
                chk($sformatf("v%0d_empty", i), 32'(empty), 32'd1);
            end else begin
                chk($sformatf("v%0d_count", i), 32'(count), 32'd0);
                chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'd0);
            end
        end

        // Fill to full, refuse the fifth store, drain in order.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_ready%0d", i), 32'(st_ready), 32'd1);
            push(3'b010, 32'h10 + 32'(4 * i), 32'(i + 1));
        end
        chk("t2_ready_full", 32'(st_ready), 32'd0);
        chk("t2_count_full", 32'(count), 32'd4);
        push(3'b010, 32'h20, 32'd5);
        chk("t2_count_refused", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1;
            #1;
            chk($sformatf("t2_drain_addr%0d", i), mem_addr, 32'h10 + 32'(4 * i));
            chk($sformatf("t2_drain_data%0d", i), mem_wdata, 32'(i + 1));
            step();
            chk($sformatf("t2_drain_count%0d", i), 32'(count), 32'(3 - i));
        end
        mem_ack = 1'b0;
        chk("t2_empty", 32'(empty), 32'd1);

        // Forwarding: sb + sh into word 0x100, younger sb overrides lane 2.
        push(3'b000, 32'h101, 32'h0000_00AB);
        ld_addr = 32'h100;
        #1;
        chk("t3_same_word_mask1", 32'(ld_fwd_mask), 32'h2);
        push(3'b001, 32'h102, 32'h0000_1234);
        #1;
        chk("t3_mask", 32'(ld_fwd_mask), 32'hE);
        chk("t3_data", ld_fwd_data, 32'h1234_AB00);
        push(3'b000, 32'h102, 32'h0000_0077);
        #1;
        chk("t3_young_mask", 32'(ld_fwd_mask), 32'hE);
        chk("t3_young_data", ld_fwd_data, 32'h1277_AB00);
        ld_addr = 32'h104;
        #1;
        chk("t3_miss_mask", 32'(ld_fwd_mask), 32'h0);
        chk("t3_miss_data", ld_fwd_data, 32'h0);
        ld_addr = 32'h100;
        mem_ack = 1'b1;
        #1;
        chk("t3_popping_mask", 32'(ld_fwd_mask), 32'hE);
        step();
        mem_ack = 1'b0;
        chk("t3_after_pop_mask", 32'(ld_fwd_mask), 32'hC);
        chk("t3_after_pop_data", ld_fwd_data, 32'h1277_0000);

        // Misaligned store with a non-empty buffer leaves count alone.
        do_reset();
        push(3'b010, 32'h200, 32'hDEAD_BEEF);
        push(3'b001, 32'h103, 32'h0000_5555);
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_head", mem_wdata, 32'hDEAD_BEEF);

        // Full + same-cycle ack: push refused, then wrap the pointers.
        do_reset();
        for (int i = 0; i < 4; i++) push(3'b010, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
        mem_ack = 1'b1;
        st_valid = 1'b1; st_funct3 = 3'b010; st_addr = 32'h80; st_wdata = 32'hFF;
        #1;
        chk("t5_ready_full", 32'(st_ready), 32'd0);
        step();
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        chk("t5_count", 32'(count), 32'd3);
        push(3'b010, 32'h84, 32'hB0);
        chk("t5_count_wrap", 32'(count), 32'd4);
        ld_addr = 32'h84;
        #1;
        chk("t5_fwd_wrapped", ld_fwd_data, 32'hB0);
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1;
            #1;
            chk($sformatf("t5_drain_addr%0d", i), mem_addr, (i < 3) ? 32'h44 + 32'(4 * i) : 32'h84);
            chk($sformatf("t5_drain_data%0d", i), mem_wdata, (i < 3) ? 32'hA1 + 32'(i) : 32'hB0);
            step();
        end
        mem_ack = 1'b0;
        chk("t5_empty", 32'(empty), 32'd1);

        // Reset mid-drain abandons all entries.
        for (int i = 0; i < 3; i++) push(3'b010, 32'h300 + 32'(4 * i), 32'(i));
        chk("t6_pre_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_req", 32'(mem_req), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        mem_ack = 1'b1;
        step();
        step();
        chk("t6_req_stays_low", 32'(mem_req), 32'd0);
        chk("t6_count_no_underflow", 32'(count), 32'd0);
        mem_ack = 1'b0;

        // Two sb to word 0x40 behind a pending head.
        push(3'b010, 32'h10, 32'h1);
        push(3'b000, 32'h40, 32'h11);
        chk("t7_count_first", 32'(count), 32'd2);
        push(3'b000, 32'h41, 32'h22);
`ifdef STORE_BUFFER_COALESCE_EN
        chk("t7_count_merged", 32'(count), 32'd2);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t7_merged_be", 32'(mem_be), 32'h3);
        chk("t7_merged_data", mem_wdata, 32'h1111_2211);
`else
        chk("t7_count_alloc", 32'(count), 32'd3);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t7_sep_be", 32'(mem_be), 32'h1);
        chk("t7_sep_data", mem_wdata, 32'h1111_1111);
`endif
        ld_addr = 32'h40;
        #1;
        chk("t7_fwd_mask", 32'(ld_fwd_mask), 32'h3);
        chk("t7_fwd_data", ld_fwd_data, 32'h0000_2211);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
